// File: rtl/osd_dii_pkg.sv
// osd_dii_pkg: shared DII flit type and FSM state encodings
// used by the ring router and the optional ring-input buffer.
package osd_dii_pkg;

  localparam int DII_DATA_WIDTH = 16;

  typedef struct packed {
    logic                      last;
    logic [DII_DATA_WIDTH-1:0] data;
  } dii_flit_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_LOCAL,
    D_FWD
  } dmx_state_e;

  typedef enum logic [1:0] {
    M_IDLE,
    M_RING,
    M_LOCAL
  } mrg_state_e;

endpackage

// File: rtl/osd_ring_router_if.sv
// osd_dii_if: one DII valid/ready flit channel.
// master drives data/last/valid, slave drives ready.
interface osd_dii_if;
  import osd_dii_pkg::*;

  logic [DII_DATA_WIDTH-1:0] data;
  logic                      last;
  logic                      valid;
  logic                      ready;

  modport master (
    output data, last, valid,
    input  ready
  );

  modport slave (
    input  data, last, valid,
    output ready
  );

endinterface

// File: rtl/osd_dii_fifo.sv
// osd_dii_fifo: DEPTH-deep {last, data} flit FIFO with
// count-based full/empty; ready and valid come from registers.
module osd_dii_fifo
  import osd_dii_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  osd_dii_if.slave  enq,
  osd_dii_if.master deq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dii_flit_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  assign enq.ready = !rst && !full;
  assign deq.valid = !rst && !empty;
  assign deq.data  = mem[rd_ptr].data;
  assign deq.last  = mem[rd_ptr].last;

  assign push = enq.valid && enq.ready;
  assign pop  = deq.valid && deq.ready;

  // Storage write; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{last: enq.last, data: enq.data};
    end
  end

  // Pointer and occupancy tracking, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/osd_ring_router.sv
// osd_ring_router: one debug-ring node; demux by destination ID,
// packet-atomic round-robin merge. Ring-input FIFO: OSD_RING_BUFFER_EN.
module osd_ring_router
  import osd_dii_pkg::*;
#(
  parameter logic [15:0] ID          = 16'h0000,
  parameter int          BUFFER_SIZE = 4
) (
  input logic       clk,
  input logic       rst,
  osd_dii_if.slave  ring_in,
  osd_dii_if.master ring_out,
  osd_dii_if.slave  local_in,
  osd_dii_if.master local_out
);

  if (BUFFER_SIZE < 2) begin : g_bad_size
    $error("BUFFER_SIZE must be at least 2");
  end

  logic [DII_DATA_WIDTH-1:0] src_data;
  logic                      src_last;
  logic                      src_valid;
  logic                      src_ready;

  dmx_state_e d_state, d_next;
  mrg_state_e m_state, m_next;
  logic       prio, prio_next;

  logic sel_local;
  logic fwd_valid;
  logic fwd_ready;
  logic grant_ring;
  logic grant_local;
  logic out_xfer;

`ifdef OSD_RING_BUFFER_EN
  osd_dii_if buf_out ();

  osd_dii_fifo #(
    .DEPTH (BUFFER_SIZE)
  ) u_fifo (
    .clk (clk),
    .rst (rst),
    .enq (ring_in),
    .deq (buf_out)
  );

  assign src_data      = buf_out.data;
  assign src_last      = buf_out.last;
  assign src_valid     = buf_out.valid;
  assign buf_out.ready = src_ready;
`else
  assign src_data      = ring_in.data;
  assign src_last      = ring_in.last;
  assign src_valid     = ring_in.valid;
  assign ring_in.ready = src_ready;
`endif

  // State registers for both FSMs and the merge priority bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state <= D_IDLE;
      m_state <= M_IDLE;
      prio    <= 1'b0;
    end else begin
      d_state <= d_next;
      m_state <= m_next;
      prio    <= prio_next;
    end
  end

  // Demux next state: latch the sink for the rest of the packet.
  always_comb begin
    d_next = d_state;
    if (src_valid && src_ready) begin
      if (src_last) begin
        d_next = D_IDLE;
      end else begin
        d_next = sel_local ? D_LOCAL : D_FWD;
      end
    end
  end

  // Demux outputs: steer head flit by ID, later flits by state.
  always_comb begin
    sel_local = 1'b0;
    unique case (d_state)
      D_LOCAL: sel_local = 1'b1;
      D_FWD:   sel_local = 1'b0;
      default: sel_local = (src_data == ID);
    endcase
    local_out.data  = src_data;
    local_out.last  = src_last;
    local_out.valid = !rst && src_valid && sel_local;
    fwd_valid       = !rst && src_valid && !sel_local;
    src_ready       = !rst &&
                      (sel_local ? local_out.ready : fwd_ready);
  end

  // Merge next state: hold the grant until the packet's last flit.
  always_comb begin
    m_next    = m_state;
    prio_next = prio;
    if (out_xfer) begin
      if (ring_out.last) begin
        m_next    = M_IDLE;
        prio_next = grant_ring;
      end else begin
        m_next = grant_ring ? M_RING : M_LOCAL;
      end
    end
  end

  // Merge outputs: grant, mux and per-source ready.
  always_comb begin
    grant_ring  = (m_state == M_RING) ||
                  ((m_state == M_IDLE) && fwd_valid &&
                   (!local_in.valid || !prio));
    grant_local = (m_state == M_LOCAL) ||
                  ((m_state == M_IDLE) && local_in.valid &&
                   (!fwd_valid || prio));
    ring_out.data  = grant_local ? local_in.data : src_data;
    ring_out.last  = grant_local ? local_in.last : src_last;
    ring_out.valid = !rst &&
                     ((grant_ring && fwd_valid) ||
                      (grant_local && local_in.valid));
    fwd_ready      = !rst && grant_ring && ring_out.ready;
    local_in.ready = !rst && grant_local && ring_out.ready;
    out_xfer       = ring_out.valid && ring_out.ready;
  end

endmodule

// File: tb/tb_osd_ring_router.sv
// tb_osd_ring_router: directed vector table plus hand sequences
// for stall, back-pressure and mid-packet reset (default build).
module tb_osd_ring_router;

  logic clk;
  logic rst;

  osd_dii_if ring_in_if ();
  osd_dii_if ring_out_if ();
  osd_dii_if local_in_if ();
  osd_dii_if local_out_if ();

  osd_ring_router #(
    .ID          (16'h0003),
    .BUFFER_SIZE (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ring_in   (ring_in_if),
    .ring_out  (ring_out_if),
    .local_in  (local_in_if),
    .local_out (local_out_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] rd;
    logic        rl;
    logic        rv;
    logic        ordy;
    logic [15:0] ld;
    logic        ll;
    logic        lv;
    logic        lrdy;
    logic        ov;
    logic [15:0] od;
    logic        ol;
    logic        lov;
    logic [15:0] lod;
    logic        lol;
    logic        rirdy;
    logic        lirdy;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(
    input logic r,
    input logic [15:0] rd, input logic rl, input logic rv,
    input logic ordy,
    input logic [15:0] ld, input logic ll, input logic lv,
    input logic lrdy,
    input logic ov, input logic [15:0] od, input logic ol,
    input logic lov, input logic [15:0] lod, input logic lol,
    input logic rirdy, input logic lirdy);
    vec_t v;
    v.rst = r; v.rd = rd; v.rl = rl; v.rv = rv; v.ordy = ordy;
    v.ld = ld; v.ll = ll; v.lv = lv; v.lrdy = lrdy;
    v.ov = ov; v.od = od; v.ol = ol;
    v.lov = lov; v.lod = lod; v.lol = lol;
    v.rirdy = rirdy; v.lirdy = lirdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one vector, check at the falling edge, then clock it in.
  task automatic apply(input vec_t v, input string tag);
    rst                = v.rst;
    ring_in_if.data    = v.rd;
    ring_in_if.last    = v.rl;
    ring_in_if.valid   = v.rv;
    ring_out_if.ready  = v.ordy;
    local_in_if.data   = v.ld;
    local_in_if.last   = v.ll;
    local_in_if.valid  = v.lv;
    local_out_if.ready = v.lrdy;
    @(negedge clk);
    chk({tag, " ring_out_valid"}, 16'(ring_out_if.valid), 16'(v.ov));
    if (v.ov) begin
      chk({tag, " ring_out_data"}, ring_out_if.data, v.od);
      chk({tag, " ring_out_last"}, 16'(ring_out_if.last), 16'(v.ol));
    end
    chk({tag, " local_out_valid"}, 16'(local_out_if.valid),
        16'(v.lov));
    if (v.lov) begin
      chk({tag, " local_out_data"}, local_out_if.data, v.lod);
      chk({tag, " local_out_last"}, 16'(local_out_if.last),
          16'(v.lol));
    end
    chk({tag, " ring_in_ready"}, 16'(ring_in_if.ready),
        16'(v.rirdy));
    chk({tag, " local_in_ready"}, 16'(local_in_if.ready),
        16'(v.lirdy));
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [14];

  initial begin
    // rst  rd      rl rv or ld      ll lv lr  ov od      ol lov lod     lol rr lr
    tbl[0]  = mk(1, 16'h0003,0,1,1, 16'h0002,1,1,1, 0,16'h0000,0, 0,16'h0000,0, 0,0);
    tbl[1]  = mk(0, 16'h0003,0,1,1, 16'h0000,0,0,1, 0,16'h0000,0, 1,16'h0003,0, 1,0);
    tbl[2]  = mk(0, 16'hAAAA,0,1,1, 16'h0000,0,0,1, 0,16'h0000,0, 1,16'hAAAA,0, 1,0);
    tbl[3]  = mk(0, 16'hBBBB,1,1,1, 16'h0000,0,0,1, 0,16'h0000,0, 1,16'hBBBB,1, 1,0);
    tbl[4]  = mk(0, 16'h0005,0,1,1, 16'h0000,0,0,1, 1,16'h0005,0, 0,16'h0000,0, 1,0);
    tbl[5]  = mk(0, 16'h1234,1,1,1, 16'h0000,0,0,1, 1,16'h1234,1, 0,16'h0000,0, 1,0);
    tbl[6]  = mk(1, 16'h0007,0,1,1, 16'h0002,0,1,1, 0,16'h0000,0, 0,16'h0000,0, 0,0);
    tbl[7]  = mk(0, 16'h0007,0,1,1, 16'h0002,0,1,1, 1,16'h0007,0, 0,16'h0000,0, 1,0);
    tbl[8]  = mk(0, 16'h1111,1,1,1, 16'h0002,0,1,1, 1,16'h1111,1, 0,16'h0000,0, 1,0);
    tbl[9]  = mk(0, 16'h0008,1,1,1, 16'h0002,0,1,1, 1,16'h0002,0, 0,16'h0000,0, 0,1);
    tbl[10] = mk(0, 16'h0008,1,1,1, 16'h2222,0,1,1, 1,16'h2222,0, 0,16'h0000,0, 0,1);
    tbl[11] = mk(0, 16'h0008,1,1,1, 16'h3333,1,1,1, 1,16'h3333,1, 0,16'h0000,0, 0,1);
    tbl[12] = mk(0, 16'h0008,1,1,1, 16'h0000,0,0,1, 1,16'h0008,1, 0,16'h0000,0, 1,0);
    tbl[13] = mk(0, 16'h0003,1,1,1, 16'h0004,1,1,1, 1,16'h0004,1, 1,16'h0003,1, 1,1);

    rst = 1'b1;
    ring_in_if.data = '0; ring_in_if.last = 0; ring_in_if.valid = 0;
    ring_out_if.ready = 1;
    local_in_if.data = '0; local_in_if.last = 0;
    local_in_if.valid = 0;
    local_out_if.ready = 1;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Local packet stalls on ring_out; pending ring packet waits.
    apply(mk(0, 16'h0000,0,0,1, 16'h0002,0,1,1,
             1,16'h0002,0, 0,16'h0000,0, 0,1), "stall_head");
    for (int i = 0; i < 5; i++) begin
      apply(mk(0, 16'h0007,1,1,0, 16'h5555,0,1,1,
               1,16'h5555,0, 0,16'h0000,0, 0,0),
            $sformatf("stall_hold%0d", i));
    end
    apply(mk(0, 16'h0007,1,1,1, 16'h5555,0,1,1,
             1,16'h5555,0, 0,16'h0000,0, 0,1), "stall_resume");
    apply(mk(0, 16'h0007,1,1,1, 16'h6666,1,1,1,
             1,16'h6666,1, 0,16'h0000,0, 0,1), "stall_last");
    apply(mk(0, 16'h0007,1,1,1, 16'h0000,0,0,1,
             1,16'h0007,1, 0,16'h0000,0, 1,0), "stall_ring");

    // Local sink back-pressure holds the ring input.
    for (int i = 0; i < 3; i++) begin
      apply(mk(0, 16'h0003,0,1,1, 16'h0000,0,0,0,
               0,16'h0000,0, 1,16'h0003,0, 0,0),
            $sformatf("bp_hold%0d", i));
    end
    apply(mk(0, 16'h0003,0,1,1, 16'h0000,0,0,1,
             0,16'h0000,0, 1,16'h0003,0, 1,0), "bp_f0");
    apply(mk(0, 16'hA001,0,1,1, 16'h0000,0,0,1,
             0,16'h0000,0, 1,16'hA001,0, 1,0), "bp_f1");
    apply(mk(0, 16'hA002,0,1,1, 16'h0000,0,0,1,
             0,16'h0000,0, 1,16'hA002,0, 1,0), "bp_f2");
    apply(mk(0, 16'hA003,1,1,1, 16'h0000,0,0,1,
             0,16'h0000,0, 1,16'hA003,1, 1,0), "bp_f3");

    // Reset in the middle of a forwarded packet.
    apply(mk(0, 16'h0005,0,1,1, 16'h0000,0,0,1,
             1,16'h0005,0, 0,16'h0000,0, 1,0), "rst_f0");
    apply(mk(0, 16'hC001,0,1,1, 16'h0000,0,0,1,
             1,16'hC001,0, 0,16'h0000,0, 1,0), "rst_f1");
    for (int i = 0; i < 2; i++) begin
      apply(mk(1, 16'hC002,0,1,1, 16'h0004,1,1,1,
               0,16'h0000,0, 0,16'h0000,0, 0,0),
            $sformatf("rst_hold%0d", i));
    end
    apply(mk(0, 16'h0009,0,1,1, 16'h0000,0,0,1,
             1,16'h0009,0, 0,16'h0000,0, 1,0), "post_f0");
    apply(mk(0, 16'h0001,1,1,1, 16'h0000,0,0,1,
             1,16'h0001,1, 0,16'h0000,0, 1,0), "post_f1");
    apply(mk(0, 16'h0003,1,1,1, 16'h0000,0,0,1,
             0,16'h0000,0, 1,16'h0003,1, 1,0), "post_local");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/osd_ring_router.md
Name: osd_ring_router

Overview:
- One node of the debug interconnect ring. One instance per ring port.
- Takes DII flits from the upstream ring segment.
  - Packets whose destination word equals the node ID are steered to the local module.
  - All other packets are forwarded downstream.
- Merges locally injected packets into the downstream ring with packet-atomic, round-robin arbitration.
- Sits directly between the host interface and the debug modules. The first instance consumes the host interface's dii_out.

Parameters:
- ID, 16'h0000, node address compared against the first flit of each packet.
- BUFFER_SIZE, 4, ring-input FIFO depth in flits (power of two, ≥2). Used only when OSD_RING_BUFFER_EN is defined.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- ring_in_data  in  16  upstream flit
- ring_in_last  in  1  last flit of packet
- ring_in_valid  in  1  upstream flit valid
- ring_in_ready  out  1  router accepts upstream flit
- ring_out_data  out  16  downstream flit
- ring_out_last  out  1  last flit of packet
- ring_out_valid  out  1  downstream flit valid
- ring_out_ready  in  1  downstream accepts flit
- local_in_data  in  16  flit injected by local module
- local_in_last  in  1  last flit of packet
- local_in_valid  in  1  injected flit valid
- local_in_ready  out  1  router accepts injected flit
- local_out_data  out  16  flit delivered to local module
- local_out_last  out  1  last flit of packet
- local_out_valid  out  1  delivered flit valid
- local_out_ready  in  1  local module accepts flit

Behaviour:
- Handshake on every channel:
  - A transfer occurs when valid and ready are both high on a rising clk edge.
  - valid must not depend on ready.
  - Data, last and valid are held stable until the transfer completes.
- Packet format: flit 0 is the destination address. A packet may be a single flit (first and last in the same cycle).
- Demux FSM (ring input side), states D_IDLE, D_LOCAL, D_FWD:
  - In D_IDLE, the first flit is steered to local_out when data == ID, otherwise to the merge path. Steering is combinational in the same cycle.
  - On a non-last transfer, move to D_LOCAL or D_FWD.
  - Stay in that state until the transfer with last=1, then return to D_IDLE.
  - ring_in_ready = ready of the selected sink. A stalled sink back-pressures only the ring input.
- Merge FSM (ring output side), states M_IDLE, M_RING, M_LOCAL; 1-bit priority register prio (0 = ring first):
  - In M_IDLE with both forward-ring and local requests valid, grant per prio. With only one request, grant it.
  - The grant is combinational in that cycle.
  - A granted non-last transfer locks the state (M_RING or M_LOCAL) until the last flit transfers.
  - On every completed packet, prio is set to favour the other source.
  - The non-granted source sees ready=0.
- Latency: 0 cycles ring_in→ring_out/local_out and local_in→ring_out (purely combinational data path) without OSD_RING_BUFFER_EN.
- Reset: FSMs go to D_IDLE/M_IDLE and prio=0. ring_out_valid=0, local_out_valid=0, ring_in_ready=0 and local_in_ready=0 for as long as rst is high.
- Reset mid-packet aborts the packet; no flits are retained.
- Ordering: flits within a packet and packets from one source are never reordered. Packets are never interleaved on ring_out.
- No buffering beyond the optional FIFO. The destination word is not modified.

Optional Feature:
- Macro OSD_RING_BUFFER_EN.
- Defined:
  - A BUFFER_SIZE-deep FIFO of {last, data} is inserted on ring_in before the demux.
  - ring_in_ready = !full (registered).
  - Minimum ring latency is 1 cycle.
  - Full and empty are tracked with a count register of clog2(BUFFER_SIZE)+1 bits; read/write pointers wrap modulo BUFFER_SIZE.
  - A simultaneous push and pop when full is disallowed because ready is already low. When empty, a pop has no effect.
  - The FIFO is cleared on rst.
- Undefined: no FIFO; 0-cycle combinational pass as above.

Decomposition:
- Package osd_dii_pkg:
  - typedef dii_flit_t {logic last; logic [15:0] data;}
  - localparam DII_DATA_WIDTH=16
  - FSM state enums for the demux and merge FSMs
- Sub-module osd_dii_fifo (parameter DEPTH) implements the optional buffer and is reusable by the host interface.

Test Plan:
- ID=16'h0003; ring_in packet {0003, AAAA, BBBB(last)}, all readies high → the same three flits appear on local_out in the same cycles; ring_out_valid stays 0.
- ID=3; ring_in packet {0005, 1234(last)} → forwarded on ring_out unchanged; local_out_valid stays 0.
- Same-cycle ring forward packet {0007, 1111(last)} and local packet {0002, 2222, 3333(last)} after reset → ring packet first (prio=0), then local. prio toggles per packet; the next contention grants local first.
- Local packet mid-transfer with ring_out_ready dropped for 5 cycles while a ring forward packet is pending → local flits stay held stable; no interleaving; the ring packet starts only after local last.
- local_out_ready=0 while a local-bound 4-flit packet arrives → ring_in_ready=0 (or FIFO fills to BUFFER_SIZE=4, then ready=0); on release, all flits are delivered in order.
- rst asserted after flit 2 of a 4-flit forwarded packet → outputs return to the reset values; the next packet {0009, 0001(last)} routes correctly from D_IDLE.
